// File: rtl/ev21g1.sv
// ev21g1: two-stage 32-bit datapath core (decode/operand-read, then execute/write-back).
// Optional multiplier for ALU func 1011 is enabled by defining EV21G1_MUL_EN.
module ev21g1 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_port0,
  input  logic [31:0] input_port1,
  input  logic [31:0] instruction,
  output logic [31:0] output_port0,
  output logic [31:0] output_port1
);

  localparam logic [5:0] OP_LDI  = 6'b100101;
  localparam logic [5:0] OP_ALU  = 6'b011000;
  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0001;
  localparam logic [3:0] FN_AND  = 4'b0010;
  localparam logic [3:0] FN_OR   = 4'b0011;
  localparam logic [3:0] FN_XOR  = 4'b0100;
  localparam logic [3:0] FN_SLL  = 4'b1000;
  localparam logic [3:0] FN_SRL  = 4'b1001;
  localparam logic [3:0] FN_SRA  = 4'b1010;
  localparam logic [3:0] FN_MUL  = 4'b1011;
  localparam logic [3:0] FN_PASS = 4'b1111;
  localparam logic [5:0] IDX_IO0 = 6'd62;
  localparam logic [5:0] IDX_IO1 = 6'd63;

  logic [31:0] regs_r [0:61];

  logic        pipe_valid_r;
  logic [5:0]  pipe_rd_r;
  logic [3:0]  pipe_func_r;
  logic [31:0] pipe_a_r;
  logic [31:0] pipe_b_r;

  logic        dec_valid_s;
  logic [5:0]  dec_rd_s;
  logic [3:0]  dec_func_s;
  logic [31:0] dec_a_s;
  logic [31:0] dec_b_s;
  logic [31:0] wb_data_s;
  logic [3:0]  unused_ign_s;

  assign unused_ign_s = instruction[25:22];

  function automatic logic [31:0] alu(input logic [3:0] func, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] res;
    case (func)
      FN_ADD:  res = a + b;
      FN_SUB:  res = a - b;
      FN_AND:  res = a & b;
      FN_OR:   res = a | b;
      FN_XOR:  res = a ^ b;
      FN_SLL:  res = a << b[4:0];
      FN_SRL:  res = a >> b[4:0];
      FN_SRA:  res = 32'($signed(a) >>> b[4:0]);
`ifdef EV21G1_MUL_EN
      FN_MUL:  res = a * b;
`endif
      default: res = a;
    endcase
    return res;
  endfunction

  // Operand read: I/O indices see the input ports; GPRs see the value retiring this edge first.
  function automatic logic [31:0] read_operand(input logic [5:0] idx);
    logic [31:0] val;
    if (idx == IDX_IO0) begin
      val = input_port0;
    end else if (idx == IDX_IO1) begin
      val = input_port1;
    end else if (pipe_valid_r && (pipe_rd_r == idx)) begin
      val = wb_data_s;
    end else begin
      val = regs_r[idx];
    end
    return val;
  endfunction

  // Stage-2 result of the instruction held in the pipeline register.
  always_comb begin
    wb_data_s = alu(pipe_func_r, pipe_a_r, pipe_b_r);
  end

  // Stage-1 decode; LDI rides through the ALU as a pass-through of its immediate.
  always_comb begin
    dec_valid_s = 1'b0;
    dec_rd_s    = instruction[5:0];
    dec_func_s  = FN_PASS;
    dec_a_s     = 32'd0;
    dec_b_s     = 32'd0;
    case (instruction[31:26])
      OP_LDI: begin
        dec_valid_s = 1'b1;
        dec_a_s     = {16'd0, instruction[21:6]};
      end
      OP_ALU: begin
        dec_func_s = instruction[21:18];
        dec_a_s    = read_operand(instruction[11:6]);
        dec_b_s    = read_operand(instruction[17:12]);
`ifdef EV21G1_MUL_EN
        dec_valid_s = 1'b1;
`else
        if (instruction[21:18] == FN_MUL) begin
          dec_valid_s = 1'b0;
        end else begin
          dec_valid_s = 1'b1;
        end
`endif
      end
      default: dec_valid_s = 1'b0;
    endcase
  end

  // Pipeline register between decode and write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid_r <= 1'b0;
      pipe_rd_r    <= 6'd0;
      pipe_func_r  <= 4'd0;
      pipe_a_r     <= 32'd0;
      pipe_b_r     <= 32'd0;
    end else begin
      pipe_valid_r <= dec_valid_s;
      pipe_rd_r    <= dec_rd_s;
      pipe_func_r  <= dec_func_s;
      pipe_a_r     <= dec_a_s;
      pipe_b_r     <= dec_b_s;
    end
  end

  // General register file write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 62; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (pipe_valid_r && (pipe_rd_r < IDX_IO0)) begin
      regs_r[pipe_rd_r] <= wb_data_s;
    end
  end

  // Memory-mapped output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_port0 <= 32'd0;
      output_port1 <= 32'd0;
    end else if (pipe_valid_r && (pipe_rd_r == IDX_IO0)) begin
      output_port0 <= wb_data_s;
    end else if (pipe_valid_r && (pipe_rd_r == IDX_IO1)) begin
      output_port1 <= wb_data_s;
    end
  end

endmodule

// File: tb/tb_ev21g1.sv
// Directed bench for ev21g1: vector table plus hand sequences for I/O, wrap, reset.
module tb_ev21g1;

  logic        clk;
  logic        rst;
  logic [31:0] input_port0;
  logic [31:0] input_port1;
  logic [31:0] instruction;
  logic [31:0] output_port0;
  logic [31:0] output_port1;

  int n_vec  = 0;
  int n_fail = 0;

  localparam logic [31:0] NOP = 32'h0FFF_FFFF;
`ifdef EV21G1_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] in0;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs [31];

  ev21g1 dut (
    .clk(clk), .rst(rst), .input_port0(input_port0), .input_port1(input_port1),
    .instruction(instruction), .output_port0(output_port0), .output_port1(output_port1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f_ldi(input logic [5:0] rd, input logic [15:0] imm);
    return {6'b100101, 4'b0000, imm, rd};
  endfunction

  function automatic logic [31:0] f_alu(input logic [3:0] fn, input logic [5:0] rd,
                                        input logic [5:0] ra, input logic [5:0] rb);
    return {6'b011000, 4'b0000, fn, rb, ra, rd};
  endfunction

  function automatic logic [31:0] f_pass(input logic [5:0] rd, input logic [5:0] ra);
    return f_alu(4'hF, rd, ra, 6'd0);
  endfunction

  task automatic step(input logic [31:0] instr, input logic [31:0] in0);
    @(negedge clk);
    instruction = instr;
    input_port0 = in0;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] m105, m64, m34, m18, last1;
    m105  = MUL_ON ? 32'd105 : 32'd0;
    m64   = MUL_ON ? 32'd64  : 32'd0;
    m34   = MUL_ON ? 32'd34  : 32'd0;
    m18   = MUL_ON ? 32'd18  : 32'd0;
    last1 = MUL_ON ? 32'd105 : 32'd8;

    // exp0/exp1 are the output ports just after the edge that samples that row.
    vecs[0]  = '{32'h9480_03C0, 32'd0, 32'd0, 32'd0};
    vecs[1]  = '{32'h9480_01C1, 32'd0, 32'd0, 32'd0};
    vecs[2]  = '{32'h9480_0402, 32'd0, 32'd0, 32'd0};
    vecs[3]  = '{32'h9480_0103, 32'd0, 32'd0, 32'd0};
    vecs[4]  = '{32'h9480_0444, 32'd0, 32'd0, 32'd0};
    vecs[5]  = '{32'h9480_0085, 32'd0, 32'd0, 32'd0};
    vecs[6]  = '{32'h9480_0486, 32'd0, 32'd0, 32'd0};
    vecs[7]  = '{32'h9480_0047, 32'd0, 32'd0, 32'd0};
    vecs[8]  = '{32'h602C_007F, 32'd0, 32'd0, 32'd0};
    vecs[9]  = '{32'h602C_20FF, 32'd0, 32'd0, m105};
    vecs[10] = '{32'h602C_417F, 32'd0, 32'd0, m64};
    vecs[11] = '{32'h602C_61FF, 32'd0, 32'd0, m34};
    vecs[12] = '{NOP,                           32'd0, 32'd0, m18};
    vecs[13] = '{f_pass(6'd62, 6'd0),           32'd0, 32'd0, m18};
    vecs[14] = '{f_pass(6'd62, 6'd1),           32'd0, 32'd15, m18};
    vecs[15] = '{f_pass(6'd62, 6'd2),           32'd0, 32'd7, m18};
    vecs[16] = '{f_pass(6'd63, 6'd7),           32'd0, 32'd16, m18};
    vecs[17] = '{NOP,                           32'd0, 32'd16, 32'd1};
    vecs[18] = '{f_ldi(6'd5, 16'd9),            32'd0, 32'd16, 32'd1};
    vecs[19] = '{f_alu(4'h0, 6'd6, 6'd5, 6'd5), 32'd0, 32'd16, 32'd1};
    vecs[20] = '{f_pass(6'd62, 6'd6),           32'd0, 32'd16, 32'd1};
    vecs[21] = '{f_alu(4'h1, 6'd62, 6'd0, 6'd2), 32'd0, 32'd18, 32'd1};
    vecs[22] = '{f_alu(4'h2, 6'd62, 6'd0, 6'd6), 32'd0, 32'hFFFF_FFFF, 32'd1};
    vecs[23] = '{f_alu(4'h3, 6'd63, 6'd0, 6'd6), 32'd0, 32'd2, 32'd1};
    vecs[24] = '{f_alu(4'h4, 6'd62, 6'd0, 6'd6), 32'd0, 32'd2, 32'd31};
    vecs[25] = '{f_alu(4'h8, 6'd62, 6'd2, 6'd3), 32'd0, 32'd29, 32'd31};
    vecs[26] = '{f_alu(4'h9, 6'd63, 6'd2, 6'd7), 32'd0, 32'd256, 32'd31};
    vecs[27] = '{f_alu(4'hA, 6'd62, 6'd62, 6'd3), 32'h8000_0000, 32'd256, 32'd8};
    vecs[28] = '{f_alu(4'h9, 6'd62, 6'd62, 6'd3), 32'h8000_0000, 32'hF800_0000, 32'd8};
    vecs[29] = '{f_alu(4'hB, 6'd63, 6'd1, 6'd0), 32'd0, 32'h0800_0000, 32'd8};
    vecs[30] = '{NOP,                           32'd0, 32'h0800_0000, last1};

    rst = 1'b1;
    instruction = NOP;
    input_port0 = 32'd0;
    input_port1 = 32'h5A5A_A5A5;
    #12;
    check("reset out0", output_port0, 32'd0);
    check("reset out1", output_port1, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 31; i++) begin
      step(vecs[i].instr, vecs[i].in0);
      check($sformatf("row%0d out0", i), output_port0, vecs[i].exp0);
      check($sformatf("row%0d out1", i), output_port1, vecs[i].exp1);
    end

    // Input port sampled at stage 1, visible at the following edge.
    step(f_alu(4'h0, 6'd62, 6'd62, 6'd10), 32'hDEAD_BEEF);
    check("io not yet", output_port0, 32'h0800_0000);
    step(NOP, 32'h1234_5678);
    check("io result", output_port0, 32'hDEAD_BEEF);

    // 0xFFFFFFFF + 1 wraps to 0.
    step(f_alu(4'h1, 6'd12, 6'd10, 6'd7), 32'd0);
    step(f_alu(4'h0, 6'd62, 6'd12, 6'd7), 32'd0);
    step(NOP, 32'd0);
    check("wrap", output_port0, 32'd0);

    // Consecutive writes to the same rd: later wins.
    step(f_ldi(6'd13, 16'd5), 32'd0);
    step(f_ldi(6'd13, 16'd6), 32'd0);
    step(f_pass(6'd63, 6'd13), 32'd0);
    step(NOP, 32'd0);
    check("last writer", output_port1, 32'd6);

    // Mid-run reset with a write to output_port1 in flight.
    step(f_pass(6'd62, 6'd0), 32'd0);
    step(f_alu(4'h0, 6'd63, 6'd0, 6'd0), 32'd0);
    check("pre-reset out0", output_port0, 32'd15);
    #2;
    rst = 1'b1;
    instruction = NOP;
    #1;
    check("async rst out0", output_port0, 32'd0);
    check("async rst out1", output_port1, 32'd0);
    @(posedge clk);
    #1;
    check("rst held out1", output_port1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in-flight dropped", output_port1, 32'd0);
    step(f_pass(6'd62, 6'd0), 32'd0);
    step(f_pass(6'd63, 6'd5), 32'd0);
    step(NOP, 32'd0);
    check("r0 cleared", output_port0, 32'd0);
    check("r5 cleared", output_port1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ev21g1.md
Name: ev21g1

Overview:
- Minimal 32-bit two-stage CPU core. It has no fetch logic: an external sequencer drives one `instruction` word per clock.
- Contains a 62-entry register file plus memory-mapped I/O on register indices 62 and 63.
- Supports load-immediate and register-register ALU operations. Results go to the register file or to two registered output ports.
- Used as the datapath/decode core beneath the system-level control.

Parameters:
- None; all widths fixed at 32-bit data and 6-bit register indices.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- input_port0  in  32  external input, read as register 62
- input_port1  in  32  external input, read as register 63
- instruction  in  32  instruction word, sampled every rising edge
- output_port0  out  32  registered output, written via rd=62
- output_port1  out  32  registered output, written via rd=63

Behaviour:
- Opcode field: [31:26].
- LDI, opcode 100101:
  - rd=[5:0], imm=[21:6] zero-extended to 32 bits.
  - [25:22] ignored.
- ALU, opcode 011000:
  - rd=[5:0], ra=[11:6], rb=[17:12], func=[21:18].
  - [25:22] ignored.
- All other opcodes (e.g. 000011, 0x0FFFFFFF) are NOP: no writes.
- func codes:
  - 0000 ADD; 0001 SUB (a-b); 0010 AND; 0011 OR; 0100 XOR.
  - 1000 SLL a by b[4:0]; 1001 SRL; 1010 SRA.
  - 1011 MUL, low 32 bits of unsigned product (see optional feature).
  - Any other func passes a through unchanged.
- All arithmetic is modulo 2^32; no flags.
- Register map:
  - Indices 0..61 are general 32-bit registers, all writable (r0 is not hardwired).
  - Read of 62 returns input_port0; read of 63 returns input_port1, as sampled at the stage-1 edge.
  - Write to 62 updates output_port0; write to 63 updates output_port1.
- Stage 1 (edge N):
  - Decode `instruction`.
  - Read ra/rb, bypassing the value being written back at the same edge N when rd matches and rd<62.
  - Latch opcode, rd, func and operands into a pipeline register.
- Stage 2 (edge N+1): compute the result and write rd (register file or output register).
- Latency:
  - An instruction applied before edge N is architecturally visible after edge N+1.
  - output_port changes immediately after edge N+1.
- Back-to-back dependent instructions need no NOPs; the bypass covers the one-cycle distance.
- Consecutive writes to the same rd: the later instruction wins.
- Reset (async, active-high), any time:
  - Register file, output_port0/1 and the pipeline register cleared to 0.
  - Pipeline register set to NOP; any in-flight write is discarded.
  - While rst is high, no writes occur.
- The first instruction after reset deasserts is sampled at the first rising edge with rst low.

Optional Feature:
- Macro EV21G1_MUL_EN.
- Defined: func 1011 performs a 32x32 multiply (low 32 bits) in stage 2, same latency as the other ALU ops.
- Undefined: no multiplier is synthesized; ALU func 1011 behaves as NOP (no register or port write).

Test Plan:
- Reset: assert rst mid-run → output_port0/1=0 immediately; all registers read 0 afterwards.
- Load immediates: LDI 0x9480_03C0, 0x9480_01C1, 0x9480_0402, 0x9480_0103, 0x9480_0444, 0x9480_0085, 0x9480_0486, 0x9480_0047, each one clock → r0..r7 = 15,7,16,4,17,2,18,1.
- With EV21G1_MUL_EN defined, directly after the loads (no NOPs) issue 0x602C_007F, 0x602C_20FF, 0x602C_417F, 0x602C_61FF (MUL rd=63), then NOP 0x0FFF_FFFF → output_port1 = 105, 64, 34, 18 on successive edges; output_port0 stays 0.
- Bypass: LDI r5=9 immediately followed by ADD r6=r5+r5 → r6=18 with no stall.
- I/O: input_port0=0xDEADBEEF; ADD rd=62, ra=62, rb=r10 (=0) → output_port0=0xDEADBEEF two edges later.
- Macro undefined: MUL to rd=63 → output_port1 unchanged. Wrap: ADD 0xFFFFFFFF+1 → 0.
